img_stream_framer: RTL

- Synthesizable framer that turns a raw 16-bit word stream (header words, then full-size pixels) into the stored image record.
- Record layout, in order:
  - header words, passed through
  - pixels, optionally thumbnail-filtered
  - 2-word Fletcher-32 checksum
  - zero padding words
- Sits directly upstream of the SD write path; its output is exactly the word stream the pixel/checksum validator consumes.

---
 rtl/img_stream_framer_pkg.sv | 30 +++
 rtl/img_stream_framer_accum.sv | 37 +++
 rtl/img_stream_framer.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/img_stream_framer_pkg.sv
// Shared definitions for the image stream framer: FSM encoding, checksum constants
// and small word helpers used by the framer and its Fletcher-32 accumulator.
package img_stream_framer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_HEADER = 3'd1,
    ST_PIXELS = 3'd2,
    ST_CKSUM0 = 3'd3,
    ST_CKSUM1 = 3'd4,
    ST_PAD    = 3'd5,
    ST_DONE   = 3'd6
  } state_t;

  localparam int          ChecksumWordCount = 2;
  localparam logic [16:0] FletcherMod       = 17'd65535;

  function automatic logic [15:0] byte_swap(input logic [15:0] w);
    return {w[7:0], w[15:8]};
  endfunction

  // One modular add step; both operands are already reduced, so one subtract suffices.
  function automatic logic [15:0] fletcher_add(input logic [15:0] a, input logic [15:0] b);
    logic [16:0] s;
    s = {1'b0, a} + {1'b0, b};
    s = (s >= FletcherMod) ? (s - FletcherMod) : s;
    return s[15:0];
  endfunction

endpackage

// File: rtl/img_stream_framer_accum.sv
// Fletcher-32 accumulator (mod 65535) with registered sums; dout = {sum2, sum1}
// reflects every word enabled up to and including the previous cycle.
module fletcher32_accum
  import img_stream_framer_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        en,
  input  logic [15:0] din,
  output logic [31:0] dout
);

  logic [15:0] r_sum1;
  logic [15:0] r_sum2;
  logic [15:0] w_sum1_nxt;
  logic [15:0] w_sum2_nxt;

  assign w_sum1_nxt = fletcher_add(r_sum1, din);
  assign w_sum2_nxt = fletcher_add(r_sum2, w_sum1_nxt);
  assign dout       = {r_sum2, r_sum1};

  // Running sums: cleared at frame start, advanced once per accepted word.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      r_sum1 <= 16'h0000;
      r_sum2 <= 16'h0000;
    end else if (en) begin
      r_sum1 <= w_sum1_nxt;
      r_sum2 <= w_sum2_nxt;
    end else begin
      r_sum1 <= r_sum1;
      r_sum2 <= r_sum2;
    end
  end

endmodule

// File: rtl/img_stream_framer.sv
// Frames a raw header+pixel word stream into a stored image record: header pass-through,
// thumbnail-filtered pixels, Fletcher-32 checksum words and zero padding.
module img_stream_framer
  import img_stream_framer_pkg::*;
#(
  parameter int DimBits = 12,
  parameter int PadBits = 16,
  parameter int HdrBits = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [HdrBits-1:0] cfg_header_words,
  input  logic [DimBits-1:0] cfg_out_width,
  input  logic [DimBits-1:0] cfg_out_height,
  input  logic [3:0]         cfg_period,
  input  logic [3:0]         cfg_keep,
  input  logic [PadBits-1:0] cfg_pad_words,
  input  logic [15:0]        s_data,
  input  logic               s_valid,
  output logic               s_ready,
  output logic [15:0]        m_data,
  output logic               m_valid,
  input  logic               m_ready,
  output logic               busy,
  output logic               done
);

  localparam int CntBits = (HdrBits > PadBits) ? HdrBits : PadBits;

  state_t             r_state, w_state_nxt;
  logic [HdrBits-1:0] r_hdr;
  logic [DimBits-1:0] r_width, r_height;
  logic [3:0]         r_period, r_keep;
  logic [PadBits-1:0] r_pad;
  logic [CntBits-1:0] r_cnt, w_cnt_nxt, w_cnt_inc;
  logic [3:0]         r_xph, r_yph, w_xph_nxt, w_yph_nxt;
  logic [DimBits-1:0] r_kept_x, r_kept_rows, w_kept_x_nxt, w_kept_rows_nxt;
  logic [DimBits-1:0] w_kept_x_inc, w_rows_inc;
  logic               r_m_valid, r_busy, r_done;
  logic [15:0]        r_m_data, w_load_data;
  logic               w_load, w_csum_en, w_csum_clr, w_out_free, w_s_ready, w_s_fire;
  logic               w_keep, w_x_wrap, w_y_wrap, w_row_end;
  logic [31:0]        w_csum;

  assign w_out_free   = !r_m_valid || m_ready;
  assign w_keep       = (r_xph < r_keep) && (r_yph < r_keep);
  assign w_s_ready    = (r_state == ST_HEADER) ? w_out_free :
                        (r_state == ST_PIXELS) ? (w_keep ? w_out_free : 1'b1) : 1'b0;
  assign w_s_fire     = s_valid && w_s_ready;
  assign w_cnt_inc    = r_cnt + CntBits'(1);
  assign w_kept_x_inc = (r_xph < r_keep) ? (r_kept_x + DimBits'(1)) : r_kept_x;
  assign w_rows_inc   = (r_yph < r_keep) ? (r_kept_rows + DimBits'(1)) : r_kept_rows;
  assign w_x_wrap     = (r_xph == (r_period - 4'd1));
  assign w_y_wrap     = (r_yph == (r_period - 4'd1));
  assign w_row_end    = w_x_wrap && (w_kept_x_inc == r_width);

  fletcher32_accum u_accum (
    .clk  (clk),
    .rst  (rst),
    .clr  (w_csum_clr),
    .en   (w_csum_en),
    .din  (byte_swap(s_data)),
    .dout (w_csum)
  );

  // Next-state, counter updates and output-register load requests.
  always_comb begin
    w_state_nxt     = r_state;
    w_load          = 1'b0;
    w_load_data     = 16'h0000;
    w_csum_en       = 1'b0;
    w_csum_clr      = 1'b0;
    w_cnt_nxt       = r_cnt;
    w_xph_nxt       = r_xph;
    w_yph_nxt       = r_yph;
    w_kept_x_nxt    = r_kept_x;
    w_kept_rows_nxt = r_kept_rows;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_csum_clr      = 1'b1;
          w_cnt_nxt       = '0;
          w_xph_nxt       = 4'd0;
          w_yph_nxt       = 4'd0;
          w_kept_x_nxt    = '0;
          w_kept_rows_nxt = '0;
          w_state_nxt     = (cfg_header_words != '0) ? ST_HEADER : ST_PIXELS;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_HEADER: begin
        if (w_s_fire) begin
          w_load      = 1'b1;
          w_load_data = s_data;
          w_csum_en   = 1'b1;
          if (w_cnt_inc == CntBits'(r_hdr)) begin
            w_cnt_nxt   = '0;
            w_state_nxt = ST_PIXELS;
          end else begin
            w_cnt_nxt = w_cnt_inc;
          end
        end else begin
          w_cnt_nxt = r_cnt;
        end
      end
      ST_PIXELS: begin
        // Dropped pixels still advance the phase counters but never reach the output.
        if (w_s_fire) begin
          w_load      = w_keep;
          w_load_data = s_data;
          w_csum_en   = w_keep;
          w_xph_nxt   = w_x_wrap ? 4'd0 : (r_xph + 4'd1);
          if (w_row_end) begin
            w_kept_x_nxt    = '0;
            w_yph_nxt       = w_y_wrap ? 4'd0 : (r_yph + 4'd1);
            w_kept_rows_nxt = w_rows_inc;
            w_state_nxt     = (w_y_wrap && (w_rows_inc == r_height)) ? ST_CKSUM0 : ST_PIXELS;
          end else begin
            w_kept_x_nxt = w_kept_x_inc;
          end
        end else begin
          w_xph_nxt = r_xph;
        end
      end
      ST_CKSUM0: begin
        if (w_out_free) begin
          w_load      = 1'b1;
          w_load_data = byte_swap(w_csum[15:0]);
          w_cnt_nxt   = '0;
          w_state_nxt = ST_CKSUM1;
        end else begin
          w_state_nxt = ST_CKSUM0;
        end
      end
      ST_CKSUM1: begin
        // r_cnt marks the second checksum word as loaded; then wait for it to drain.
        if (r_cnt == '0) begin
          if (w_out_free) begin
            w_load      = 1'b1;
            w_load_data = byte_swap(w_csum[31:16]);
            w_cnt_nxt   = (r_pad != '0) ? '0 : CntBits'(1);
            w_state_nxt = (r_pad != '0) ? ST_PAD : ST_CKSUM1;
          end else begin
            w_state_nxt = ST_CKSUM1;
          end
        end else begin
          w_state_nxt = w_out_free ? ST_DONE : ST_CKSUM1;
        end
      end
      ST_PAD: begin
        if (w_out_free) begin
          if (r_cnt == CntBits'(r_pad)) begin
            w_state_nxt = ST_DONE;
          end else begin
            w_load    = 1'b1;
            w_cnt_nxt = w_cnt_inc;
          end
        end else begin
          w_state_nxt = ST_PAD;
        end
      end
      ST_DONE: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // State, counters, latched configuration, output register and status flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_hdr       <= '0;
      r_width     <= '0;
      r_height    <= '0;
      r_period    <= 4'd1;
      r_keep      <= 4'd1;
      r_pad       <= '0;
      r_cnt       <= '0;
      r_xph       <= 4'd0;
      r_yph       <= 4'd0;
      r_kept_x    <= '0;
      r_kept_rows <= '0;
      r_m_valid   <= 1'b0;
      r_m_data    <= 16'h0000;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      if ((r_state == ST_IDLE) && start) begin
        r_hdr    <= cfg_header_words;
        r_width  <= cfg_out_width;
        r_height <= cfg_out_height;
        r_period <= cfg_period;
        r_keep   <= cfg_keep;
        r_pad    <= cfg_pad_words;
      end else begin
        r_hdr <= r_hdr;
      end
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_xph       <= w_xph_nxt;
      r_yph       <= w_yph_nxt;
      r_kept_x    <= w_kept_x_nxt;
      r_kept_rows <= w_kept_rows_nxt;
      if (w_load) begin
        r_m_valid <= 1'b1;
        r_m_data  <= w_load_data;
      end else if (m_ready) begin
        r_m_valid <= 1'b0;
      end else begin
        r_m_valid <= r_m_valid;
      end
      r_busy <= (w_state_nxt != ST_IDLE);
      r_done <= (w_state_nxt == ST_DONE);
    end
  end

  assign s_ready = w_s_ready;
  assign m_valid = r_m_valid;
  assign m_data  = r_m_data;
  assign busy    = r_busy;
  assign done    = r_done;

endmodule
